ibex_load_store_unit: RTL and testbench

- Data-memory interface stage directly downstream of ibex_id_stage.
- Consumes the ID/EX load/store request (req, we, type, sign-extend, wdata) and the ALU-computed byte address.
- Drives the core data bus (req/gnt/rvalid).
- Returns load data, the valid pulse, address-increment status and load/store error flags that the ID stage uses for write-back and exception handling.

---
 rtl/ibex_pkg.sv | 57 +++++
 rtl/ibex_lsu_rdata_align.sv | 29 ++
 rtl/ibex_load_store_unit.sv | 199 +++++++++++++++++++
 tb/tb_ibex_load_store_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared types and constants for the load/store unit: FSM states, data
// type encodings, byte-enable base patterns and small lane helpers.
package ibex_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GNT_MIS,
        WAIT_RVALID_MIS,
        WAIT_GNT,
        WAIT_RVALID
    } lsu_state_e;

    // Data type encoding on lsu_type; 2'b11 is handled as a word.
    localparam logic [1:0] DT_WORD = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_BYTE = 2'b10;

    // Byte-enable patterns before shifting by the byte offset.
    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_BYTE = 4'b0001;

    // An access is split when it crosses a word boundary.
    function automatic logic is_split(input logic [1:0] dtype, input logic [1:0] off);
        case (dtype)
            DT_HALF: return off == 2'd3;
            DT_BYTE: return 1'b0;
            default: return off != 2'd0;
        endcase
    endfunction

    // Byte enables of the first (or only) bus transaction.
    function automatic logic [3:0] be_first(input logic [1:0] dtype, input logic [1:0] off);
        case (dtype)
            DT_HALF: return BE_HALF << off;
            DT_BYTE: return BE_BYTE << off;
            default: return BE_WORD << off;
        endcase
    endfunction

    // Byte enables of the second transaction of a split access; only a
    // half at offset 3 splits among halves, so its tail is always byte 0.
    function automatic logic [3:0] be_second(input logic [1:0] dtype, input logic [1:0] off);
        case (dtype)
            DT_HALF: return BE_BYTE;
            default: return ~(BE_WORD << off);
        endcase
    endfunction

    // Store data rotated left by whole bytes so each byte lands on its lane.
    function automatic logic [31:0] rotate_wdata(input logic [31:0] wdata, input logic [1:0] off);
        logic [63:0] twice;
        twice = {wdata, wdata} << {off, 3'b000};
        return twice[63:32];
    endfunction

endpackage

// File: rtl/ibex_lsu_rdata_align.sv
// Load data alignment: shifts the returned word(s) down by the byte offset,
// joins the two halves of a split access, then extracts and extends the size.
module ibex_lsu_rdata_align
    import ibex_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] rdata_q,
    input  logic [1:0]  off,
    input  logic [1:0]  dtype,
    input  logic        sext,
    input  logic        split,
    output logic [31:0] result
);

    logic [63:0] joined;
    logic [63:0] shifted;

    // Shift the (possibly two-word) response down and extend to 32 bits.
    always_comb begin
        joined  = split ? {rdata, rdata_q} : {32'h0, rdata};
        shifted = joined >> {off, 3'b000};
        case (dtype)
            DT_HALF: result = {{16{sext & shifted[15]}}, shifted[15:0]};
            DT_BYTE: result = {{24{sext & shifted[7]}}, shifted[7:0]};
            default: result = shifted[31:0];
        endcase
    end

endmodule

// File: rtl/ibex_load_store_unit.sv
// Load/store unit: turns the ID/EX request into one or two data-bus
// transactions and reports the result back to the ID stage.
// Optional build macro IBEX_LSU_MISALIGNED_TRAP_EN: word-crossing accesses
// never reach the bus and instead complete next cycle with an error.
// Handshake: data_req_o holds address, byte enables, write data and write
// enable stable until the cycle data_gnt_i is high; the single outstanding
// transaction ends with data_rvalid_i, which qualifies data_err_i/rdata.
module ibex_load_store_unit
    import ibex_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [31:0] adder_result_ex_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_rdata_valid_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_addr_incr_req_o,
    output logic [31:0] lsu_addr_last_o,
    output logic        lsu_load_err_o,
    output logic        lsu_store_err_o,
    output logic        busy_o
);

    lsu_state_e  state_q;
    logic [31:0] addr_q;
    logic [31:0] rdata_q;
    logic [31:0] addr_last_q;
    logic [1:0]  off_q;
    logic [1:0]  type_q;
    logic        we_q;
    logic        sext_q;
    logic        err_q;
    logic        second_q;
    logic        trap_q;

    logic [1:0]  off_in;
    logic        split_in;
    logic        idle_issue;
    logic [31:0] addr_next_word;
    logic        final_rsp;
    logic        err_total;
    logic        second_fault;
    logic [31:0] aligned_rdata;

    assign off_in         = adder_result_ex_i[1:0];
    assign split_in       = is_split(lsu_type_i, off_in);
    assign addr_next_word = {addr_q[31:2] + 30'd1, 2'b00};

`ifdef IBEX_LSU_MISALIGNED_TRAP_EN
    assign idle_issue = lsu_req_i & ~split_in;
`else
    assign idle_issue = lsu_req_i;
    assign trap_q     = 1'b0;
`endif

    assign final_rsp    = (state_q == WAIT_RVALID) & (data_rvalid_i | trap_q);
    assign err_total    = err_q | trap_q | data_err_i;
    assign second_fault = final_rsp & second_q & data_err_i & ~err_q;

    // Bus request side: IDLE forwards the incoming request, WAIT_GNT* replay the captured one.
    always_comb begin
        data_req_o   = 1'b0;
        data_addr_o  = 32'h0;
        data_be_o    = 4'b0000;
        data_wdata_o = 32'h0;
        data_we_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (idle_issue) begin
                    data_req_o   = 1'b1;
                    data_addr_o  = {adder_result_ex_i[31:2], 2'b00};
                    data_be_o    = be_first(lsu_type_i, off_in);
                    data_wdata_o = rotate_wdata(lsu_wdata_i, off_in);
                    data_we_o    = lsu_we_i;
                end
            end
            WAIT_GNT_MIS: begin
                data_req_o   = 1'b1;
                data_addr_o  = {addr_q[31:2], 2'b00};
                data_be_o    = be_first(type_q, off_q);
                data_wdata_o = rotate_wdata(lsu_wdata_i, off_q);
                data_we_o    = we_q;
            end
            WAIT_GNT: begin
                data_req_o   = 1'b1;
                data_addr_o  = second_q ? addr_next_word : {addr_q[31:2], 2'b00};
                data_be_o    = second_q ? be_second(type_q, off_q) : be_first(type_q, off_q);
                data_wdata_o = rotate_wdata(lsu_wdata_i, off_q);
                data_we_o    = we_q;
            end
            default: ;
        endcase
    end

    // Access sequencing and capture of request attributes, first-part data and errors.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= 32'h0;
            rdata_q     <= 32'h0;
            addr_last_q <= 32'h0;
            off_q       <= 2'b00;
            type_q      <= 2'b00;
            we_q        <= 1'b0;
            sext_q      <= 1'b0;
            err_q       <= 1'b0;
            second_q    <= 1'b0;
`ifdef IBEX_LSU_MISALIGNED_TRAP_EN
            trap_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (lsu_req_i) begin
                        addr_q      <= adder_result_ex_i;
                        addr_last_q <= adder_result_ex_i;
                        off_q       <= off_in;
                        type_q      <= lsu_type_i;
                        we_q        <= lsu_we_i;
                        sext_q      <= lsu_sign_ext_i;
                        err_q       <= 1'b0;
                        second_q    <= 1'b0;
`ifdef IBEX_LSU_MISALIGNED_TRAP_EN
                        trap_q      <= split_in;
                        if (split_in)        state_q <= WAIT_RVALID;
                        else if (data_gnt_i) state_q <= WAIT_RVALID;
                        else                 state_q <= WAIT_GNT;
`else
                        if (split_in) state_q <= data_gnt_i ? WAIT_RVALID_MIS : WAIT_GNT_MIS;
                        else          state_q <= data_gnt_i ? WAIT_RVALID : WAIT_GNT;
`endif
                    end
                end
`ifdef IBEX_LSU_MISALIGNED_TRAP_EN
                // Split accesses trap instead of using the two-part states.
`else
                WAIT_GNT_MIS: begin
                    if (data_gnt_i) state_q <= WAIT_RVALID_MIS;
                end
                WAIT_RVALID_MIS: begin
                    if (data_rvalid_i) begin
                        rdata_q  <= data_rdata_i;
                        err_q    <= data_err_i;
                        second_q <= 1'b1;
                        state_q  <= WAIT_GNT;
                    end
                end
`endif
                WAIT_GNT: begin
                    if (data_gnt_i) state_q <= WAIT_RVALID;
                end
                WAIT_RVALID: begin
                    if (final_rsp) begin
                        state_q <= IDLE;
                        if (second_fault) addr_last_q <= addr_next_word;
`ifdef IBEX_LSU_MISALIGNED_TRAP_EN
                        trap_q  <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    ibex_lsu_rdata_align u_rdata_align (
        .rdata   (data_rdata_i),
        .rdata_q (rdata_q),
        .off     (off_q),
        .dtype   (type_q),
        .sext    (sext_q),
        .split   (second_q),
        .result  (aligned_rdata)
    );

    assign lsu_resp_valid_o    = final_rsp;
    assign lsu_rdata_valid_o   = final_rsp & ~we_q & ~err_total;
    assign lsu_rdata_o         = lsu_rdata_valid_o ? aligned_rdata : 32'h0;
    assign lsu_load_err_o      = final_rsp & err_total & ~we_q;
    assign lsu_store_err_o     = final_rsp & err_total & we_q;
    assign lsu_addr_incr_req_o = (state_q == WAIT_RVALID_MIS) & data_rvalid_i;
    assign lsu_addr_last_o     = second_fault ? addr_next_word : addr_last_q;
    assign busy_o              = state_q != IDLE;

endmodule

// File: tb/tb_ibex_load_store_unit.sv
// Directed bench for ibex_load_store_unit: a table of accesses driven
// through a small bus responder, plus reset and trap sequences.
module tb_ibex_load_store_unit;
    import ibex_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        lsu_req;
    logic        lsu_we;
    logic [1:0]  lsu_type;
    logic        lsu_sign_ext;
    logic [31:0] lsu_wdata;
    logic [31:0] adder_result;
    logic        data_req;
    logic        data_gnt;
    logic        data_rvalid;
    logic        data_err;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic [31:0] lsu_rdata;
    logic        lsu_rdata_valid;
    logic        lsu_resp_valid;
    logic        lsu_addr_incr_req;
    logic [31:0] lsu_addr_last;
    logic        lsu_load_err;
    logic        lsu_store_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        we;
        logic [1:0]  dtype;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic        err1;
        logic        err2;
        int          gdly;
        logic        split;
        logic [31:0] exp_addr1;
        logic [31:0] exp_addr2;
        logic [3:0]  exp_be1;
        logic [3:0]  exp_be2;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_addr_last;
    } vec_t;

    vec_t vecs[13];

    ibex_load_store_unit dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .lsu_req_i           (lsu_req),
        .lsu_we_i            (lsu_we),
        .lsu_type_i          (lsu_type),
        .lsu_sign_ext_i      (lsu_sign_ext),
        .lsu_wdata_i         (lsu_wdata),
        .adder_result_ex_i   (adder_result),
        .data_req_o          (data_req),
        .data_gnt_i          (data_gnt),
        .data_rvalid_i       (data_rvalid),
        .data_err_i          (data_err),
        .data_addr_o         (data_addr),
        .data_we_o           (data_we),
        .data_be_o           (data_be),
        .data_wdata_o        (data_wdata),
        .data_rdata_i        (data_rdata),
        .lsu_rdata_o         (lsu_rdata),
        .lsu_rdata_valid_o   (lsu_rdata_valid),
        .lsu_resp_valid_o    (lsu_resp_valid),
        .lsu_addr_incr_req_o (lsu_addr_incr_req),
        .lsu_addr_last_o     (lsu_addr_last),
        .lsu_load_err_o      (lsu_load_err),
        .lsu_store_err_o     (lsu_store_err),
        .busy_o              (busy)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic we, input logic [1:0] dtype, input logic sext,
        input logic [31:0] addr, input logic [31:0] wdata,
        input logic [31:0] rdata1, input logic [31:0] rdata2,
        input logic err1, input logic err2, input int gdly, input logic split,
        input logic [31:0] exp_addr1, input logic [31:0] exp_addr2,
        input logic [3:0] exp_be1, input logic [3:0] exp_be2,
        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
        input logic exp_err, input logic [31:0] exp_addr_last);
        vec_t v;
        v.we = we; v.dtype = dtype; v.sext = sext; v.addr = addr; v.wdata = wdata;
        v.rdata1 = rdata1; v.rdata2 = rdata2; v.err1 = err1; v.err2 = err2;
        v.gdly = gdly; v.split = split;
        v.exp_addr1 = exp_addr1; v.exp_addr2 = exp_addr2;
        v.exp_be1 = exp_be1; v.exp_be2 = exp_be2;
        v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata;
        v.exp_err = exp_err; v.exp_addr_last = exp_addr_last;
        return v;
    endfunction

    task automatic clear_bus();
        data_gnt    = 1'b0;
        data_rvalid = 1'b0;
        data_err    = 1'b0;
        data_rdata  = 32'h0;
    endtask

    // Driver and bus responder for one table entry; checks every bus cycle
    // and the completion pulse, and feeds load results to the scoreboard.
    task automatic run_vec(input int idx, input vec_t v);
        int   part;
        int   gcnt;
        bit   pend;
        bit   done;
        bit   last;
        int   stray;
        int   exp_cyc;
        string tag;
        part = 0; gcnt = v.gdly; pend = 0; done = 0; stray = 0;
        exp_cyc = v.split ? 2 * v.gdly + 3 : v.gdly + 1;
        tag = $sformatf("v%0d", idx);
        if (!v.we && !v.exp_err) exp_q.push_back(v.exp_rdata);
        @(negedge clk);
        lsu_req      = 1'b1;
        lsu_we       = v.we;
        lsu_type     = v.dtype;
        lsu_sign_ext = v.sext;
        lsu_wdata    = v.wdata;
        adder_result = v.addr;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            clear_bus();
            last = 1'b0;
            if (pend) begin
                pend        = 1'b0;
                data_rvalid = 1'b1;
                data_rdata  = (part == 0) ? v.rdata1 : v.rdata2;
                data_err    = (part == 0) ? v.err1 : v.err2;
                last        = (part == 1) || !v.split;
                if (last) lsu_req = 1'b0;
            end
            #1;
            if (data_req) begin
                chk({tag, "_addr"},  data_addr,  (part == 0) ? v.exp_addr1 : v.exp_addr2);
                chk({tag, "_be"},    {28'h0, data_be}, {28'h0, (part == 0) ? v.exp_be1 : v.exp_be2});
                chk({tag, "_wdata"}, data_wdata, v.exp_wdata);
                chk({tag, "_we"},    {31'h0, data_we}, {31'h0, v.we});
                if (gcnt == 0) begin
                    data_gnt = 1'b1;
                    pend     = 1'b1;
                end else begin
                    gcnt--;
                end
            end
            if (data_rvalid) begin
                chk({tag, "_incr"}, {31'h0, lsu_addr_incr_req}, {31'h0, !last});
                chk({tag, "_resp"}, {31'h0, lsu_resp_valid},    {31'h0, last});
                if (last) begin
                    done = 1'b1;
                    chk({tag, "_rvalid"},   {31'h0, lsu_rdata_valid}, {31'h0, !v.we && !v.exp_err});
                    chk({tag, "_lerr"},     {31'h0, lsu_load_err},    {31'h0, v.exp_err && !v.we});
                    chk({tag, "_serr"},     {31'h0, lsu_store_err},   {31'h0, v.exp_err && v.we});
                    chk({tag, "_addrlast"}, lsu_addr_last, v.exp_addr_last);
                    chk({tag, "_latency"},  cyc, exp_cyc);
                    if (lsu_rdata_valid) begin
                        if (exp_q.size() == 0) chk({tag, "_unexpected_rdata"}, lsu_rdata, 32'hxxxxxxxx);
                        else chk({tag, "_rdata"}, lsu_rdata, exp_q.pop_front());
                    end
                end else begin
                    part = 1;
                    gcnt = v.gdly;
                end
            end else if (lsu_resp_valid || lsu_addr_incr_req) begin
                stray++;
            end
            @(negedge clk);
        end
        clear_bus();
        lsu_req = 1'b0;
        if (!done) chk({tag, "_timeout"}, 32'h0, 32'h1);
        chk({tag, "_stray_pulses"}, stray, 0);
        #1;
        chk({tag, "_busy_after"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        // Directed table
        vecs[0]  = mk(0, DT_WORD, 0, 32'h00001000, 32'hCAFEF00D, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0,
                      32'h00001000, 32'h0, 4'b1111, 4'b0000, 32'hCAFEF00D, 32'hDEADBEEF, 0, 32'h00001000);
        vecs[1]  = mk(0, DT_BYTE, 1, 32'h00002003, 32'h000000AA, 32'h80112233, 32'h0, 0, 0, 0, 0,
                      32'h00002000, 32'h0, 4'b1000, 4'b0000, 32'hAA000000, 32'hFFFFFF80, 0, 32'h00002003);
        vecs[2]  = mk(0, DT_BYTE, 0, 32'h00002003, 32'h000000AA, 32'h80112233, 32'h0, 0, 0, 0, 0,
                      32'h00002000, 32'h0, 4'b1000, 4'b0000, 32'hAA000000, 32'h00000080, 0, 32'h00002003);
        vecs[3]  = mk(1, DT_WORD, 0, 32'h00003001, 32'h11223344, 32'h0, 32'h0, 0, 0, 0, 1,
                      32'h00003000, 32'h00003004, 4'b1110, 4'b0001, 32'h22334411, 32'h0, 0, 32'h00003001);
        vecs[4]  = mk(0, DT_WORD, 0, 32'h00004002, 32'h0, 32'h11111111, 32'h22222222, 1, 0, 0, 1,
                      32'h00004000, 32'h00004004, 4'b1100, 4'b0011, 32'h0, 32'h0, 1, 32'h00004002);
        vecs[5]  = mk(0, DT_WORD, 0, 32'h00001004, 32'hA5A5A5A5, 32'h12345678, 32'h0, 0, 0, 3, 0,
                      32'h00001004, 32'h0, 4'b1111, 4'b0000, 32'hA5A5A5A5, 32'h12345678, 0, 32'h00001004);
        vecs[6]  = mk(0, DT_HALF, 1, 32'h00006002, 32'h0, 32'h80017FFF, 32'h0, 0, 0, 1, 0,
                      32'h00006000, 32'h0, 4'b1100, 4'b0000, 32'h0, 32'hFFFF8001, 0, 32'h00006002);
        vecs[7]  = mk(0, DT_HALF, 0, 32'h00006003, 32'h0000BEEF, 32'hCD112233, 32'h445566EF, 0, 0, 0, 1,
                      32'h00006000, 32'h00006004, 4'b1000, 4'b0001, 32'hEF0000BE, 32'h0000EFCD, 0, 32'h00006003);
        vecs[8]  = mk(0, DT_WORD, 1, 32'hFFFFFFFE, 32'h0, 32'h01020304, 32'h05060708, 0, 1, 0, 1,
                      32'hFFFFFFFC, 32'h00000000, 4'b1100, 4'b0011, 32'h0, 32'h0, 1, 32'h00000000);
        vecs[9]  = mk(1, DT_BYTE, 0, 32'h00007002, 32'h000000C3, 32'h0, 32'h0, 1, 0, 0, 0,
                      32'h00007000, 32'h0, 4'b0100, 4'b0000, 32'h00C30000, 32'h0, 1, 32'h00007002);
        vecs[10] = mk(1, DT_HALF, 0, 32'h00007001, 32'h0000A1B2, 32'h0, 32'h0, 0, 0, 2, 0,
                      32'h00007000, 32'h0, 4'b0110, 4'b0000, 32'h00A1B200, 32'h0, 0, 32'h00007001);
        vecs[11] = mk(0, 2'b11, 0, 32'h00008000, 32'h0, 32'h0F0F0F0F, 32'h0, 0, 0, 0, 0,
                      32'h00008000, 32'h0, 4'b1111, 4'b0000, 32'h0, 32'h0F0F0F0F, 0, 32'h00008000);
        vecs[12] = mk(0, DT_WORD, 0, 32'h00009003, 32'h01020304, 32'h11223344, 32'h55667788, 0, 0, 1, 1,
                      32'h00009000, 32'h00009004, 4'b1000, 4'b0111, 32'h04010203, 32'h66778811, 0, 32'h00009003);

        // Reset state
        rst_n = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_type = DT_WORD;
        lsu_sign_ext = 1'b0; lsu_wdata = 32'h0; adder_result = 32'h0;
        clear_bus();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy",     {31'h0, busy},           32'h0);
        chk("rst_req",      {31'h0, data_req},       32'h0);
        chk("rst_resp",     {31'h0, lsu_resp_valid}, 32'h0);
        chk("rst_addrlast", lsu_addr_last,           32'h0);
        chk("rst_be",       {28'h0, data_be},        32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
`ifdef IBEX_LSU_MISALIGNED_TRAP_EN
            if (!vecs[i].split) run_vec(i, vecs[i]);
`else
            run_vec(i, vecs[i]);
`endif
        end

        // Reset during WAIT_RVALID after a 3-cycle grant delay
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_type = DT_WORD; adder_result = 32'h00001000;
        lsu_wdata = 32'h13579BDF;
        for (int c = 0; c < 4; c++) begin
            clear_bus();
            #1;
            chk("rstseq_req",  {31'h0, data_req}, 32'h1);
            chk("rstseq_addr", data_addr, 32'h00001000);
            if (c == 3) data_gnt = 1'b1;
            @(negedge clk);
        end
        clear_bus();
        lsu_req = 1'b0;
        #1;
        chk("rstseq_busy_before", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rstseq_busy",     {31'h0, busy},            32'h0);
        chk("rstseq_dreq",     {31'h0, data_req},        32'h0);
        chk("rstseq_addr0",    data_addr,                32'h0);
        chk("rstseq_resp",     {31'h0, lsu_resp_valid},  32'h0);
        chk("rstseq_addrlast", lsu_addr_last,            32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            data_rvalid = (c == 0);
            data_rdata  = 32'h55555555;
            #1;
            chk("rstseq_late_resp",   {31'h0, lsu_resp_valid},  32'h0);
            chk("rstseq_late_rvalid", {31'h0, lsu_rdata_valid}, 32'h0);
            chk("rstseq_late_busy",   {31'h0, busy},            32'h0);
        end
        clear_bus();

`ifdef IBEX_LSU_MISALIGNED_TRAP_EN
        // Split half load traps without touching the bus
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_type = DT_HALF; lsu_sign_ext = 1'b0;
        adder_result = 32'h00005003;
        #1;
        chk("trap_req0", {31'h0, data_req}, 32'h0);
        @(negedge clk);
        lsu_req = 1'b0;
        #1;
        chk("trap_req1",     {31'h0, data_req},       32'h0);
        chk("trap_resp",     {31'h0, lsu_resp_valid}, 32'h1);
        chk("trap_lerr",     {31'h0, lsu_load_err},   32'h1);
        chk("trap_addrlast", lsu_addr_last,           32'h00005003);
        @(negedge clk);
        #1;
        chk("trap_busy_after", {31'h0, busy}, 32'h0);
`endif

        // Final report
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
